// File: rtl/modular_inverter.sv
// modular_inverter -- computes d = e^-1 mod phi with the extended Euclidean
// algorithm.
//
// The quotient of each Euclid step comes from a 16-cycle restoring
// shift-subtract divider that is time-shared with the optional
// self-check reduction.
//
// Optional feature: define MODINV_SELFCHECK_EN to add a CHECK state after
// FIX. CHECK reduces e*d mod phi over 32 cycles and drops valid (and d)
// unless the result is 1.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   start    : single-cycle request, accepted in IDLE or DONE
//   e        : public exponent (captured in LOAD)
//   phi      : modulus (captured in LOAD)
//   busy     : computation in progress (LOAD/DIV/UPDATE/FIX[/CHECK])
//   finished : result available (DONE), cleared by the next accepted start
//   valid    : inverse exists
//   d        : inverse in [1, phi-1], or 0 when valid=0
module modular_inverter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] e,
  input  logic [15:0] phi,
  output logic        busy,
  output logic        finished,
  output logic        valid,
  output logic [15:0] d
);

`ifdef MODINV_SELFCHECK_EN
  typedef enum logic [2:0] {IDLE, LOAD, DIV, UPDATE, FIX, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DIV, UPDATE, FIX, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] r0_q, r0_d, r1_q, r1_d;
  logic [17:0] t0_q, t0_d, t1_q, t1_d;
  logic [15:0] e_q, e_d, phi_q, phi_d;
  logic [15:0] quo_q, quo_d;   // dividend shifting out / quotient shifting in
  logic [15:0] rem_q, rem_d;   // partial remainder, always < divisor
  logic [4:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [15:0] d_q, d_d;
`ifdef MODINV_SELFCHECK_EN
  logic [31:0] prod_q, prod_d;
`endif

  // Shared shift-subtract step: the divider consumes quotient bits of r0,
  // the self-check consumes bits of e*d; divisor is r1 or phi respectively.
  logic        src_bit;
  logic [15:0] divisor;
  logic [16:0] rem_sh;
  logic        ge;
  logic [15:0] rem_nx;
  logic [17:0] qt;
  logic        fix_ok;
  logic [15:0] d_fix;

  always_comb begin
`ifdef MODINV_SELFCHECK_EN
    src_bit = (state_q == CHECK) ? prod_q[31] : quo_q[15];
    divisor = (state_q == CHECK) ? phi_q : r1_q;
`else
    src_bit = quo_q[15];
    divisor = r1_q;
`endif
    rem_sh = {rem_q, src_bit};
    ge     = (rem_sh >= {1'b0, divisor});
    rem_nx = ge ? 16'(rem_sh - {1'b0, divisor}) : rem_sh[15:0];
    // |t1| <= phi, so the 18-bit truncated product is exact.
    qt     = {2'b00, quo_q} * t1_q;
    // Degenerate inputs (phi<2, e==0) can still end with r0==1; reject them.
    fix_ok = (r0_q == 16'd1) && (phi_q >= 16'd2) && (e_q != 16'd0);
    // True result lies in [1, phi-1], so the low 16 bits are exact.
    d_fix  = 16'(t0_q + (t0_q[17] ? {2'b00, phi_q} : 18'd0));
  end

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    e_d     = e_q;
    phi_d   = phi_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    d_d     = d_q;
`ifdef MODINV_SELFCHECK_EN
    prod_d  = prod_q;
`endif
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD: begin
        r0_d    = phi;
        r1_d    = e;
        t0_d    = 18'd0;
        t1_d    = 18'd1;
        e_d     = e;
        phi_d   = phi;
        quo_d   = phi;
        rem_d   = 16'd0;
        cnt_d   = 5'd0;
        valid_d = 1'b0;
        d_d     = 16'd0;
        state_d = (e != 16'd0) ? DIV : FIX;
      end
      DIV: begin
        quo_d = {quo_q[14:0], ge};
        rem_d = rem_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) state_d = UPDATE;
      end
      UPDATE: begin
        // quo_q holds q, rem_q holds r0 - q*r1.
        r0_d    = r1_q;
        r1_d    = rem_q;
        t0_d    = t1_q;
        t1_d    = t0_q - qt;
        quo_d   = r1_q;
        rem_d   = 16'd0;
        cnt_d   = 5'd0;
        state_d = (rem_q != 16'd0) ? DIV : FIX;
      end
      FIX: begin
        valid_d = fix_ok;
        d_d     = fix_ok ? d_fix : 16'd0;
`ifdef MODINV_SELFCHECK_EN
        prod_d  = {16'd0, e_q} * {16'd0, (fix_ok ? d_fix : 16'd0)};
        rem_d   = 16'd0;
        cnt_d   = 5'd0;
        state_d = CHECK;
`else
        state_d = DONE;
`endif
      end
`ifdef MODINV_SELFCHECK_EN
      CHECK: begin
        prod_d = {prod_q[30:0], 1'b0};
        rem_d  = rem_nx;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          if (rem_nx != 16'd1) begin
            valid_d = 1'b0;
            d_d     = 16'd0;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      e_q     <= '0;
      phi_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      d_q     <= '0;
`ifdef MODINV_SELFCHECK_EN
      prod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      e_q     <= e_d;
      phi_q   <= phi_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      d_q     <= d_d;
`ifdef MODINV_SELFCHECK_EN
      prod_q  <= prod_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign finished = (state_q == DONE);
  assign valid    = valid_q;
  assign d        = d_q;

endmodule
